// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a
// 32-entry scoreboard of destinations that are reserved but not yet written back.
module regfile_write_arbiter #(
    parameter int unsigned N_REQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [5*N_REQ-1:0]    req_addr,
    input  logic [32*N_REQ-1:0]   req_data,
    input  logic                  rsv_valid,
    input  logic [4:0]            rsv_addr,
    output logic                  rsv_ready,
    input  logic                  flush,
    output logic [31:0]           busy,
    output logic                  wr_ena,
    output logic [4:0]            wr_addr,
    output logic [31:0]           wr_data
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_any;
    logic [N_REQ-1:0] grant;
    logic [4:0]       sel_addr;
    logic [31:0]      sel_data;
    logic [31:0]      busy_q;
    logic [31:0]      busy_d;

    // Two passes: indices at or above the pointer first, then the wrapped-around ones.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && req_valid[i] && (PTR_W'(i) >= ptr_q)) begin
                grant_any = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = PTR_W'(i);
                sel_addr  = req_addr[5*i +: 5];
                sel_data  = req_data[32*i +: 32];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && req_valid[i] && (PTR_W'(i) < ptr_q)) begin
                grant_any = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = PTR_W'(i);
                sel_addr  = req_addr[5*i +: 5];
                sel_data  = req_data[32*i +: 32];
            end
        end
    end

    assign req_ready = grant;

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign rsv_ready = rsv_valid & ~busy_q[rsv_addr] & ~flush;

    // Clear is applied after set; a same-register collision never sets anyway
    // because rsv_ready is low while the bit is busy.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (rsv_ready) begin
                busy_d[rsv_addr] = 1'b1;
            end
            if (grant_any) begin
                busy_d[sel_addr] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    assign busy = busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            busy_q  <= '0;
            wr_ena  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            if (grant_any) begin
                // x0 writes are accepted but never reach the register file enabled
                wr_ena  <= (sel_addr != 5'd0);
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end else begin
                wr_ena <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table for single-cycle behaviour,
// hand-written sequences for asynchronous reset and round-robin streaming.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rsv_ready;
    logic        flush;
    logic [31:0] busy;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.N_REQ(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .flush     (flush),
        .busy      (busy),
        .wr_ena    (wr_ena),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rv;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        rsv_v;
        logic [4:0]  rsv_a;
        logic        fl;
        logic [1:0]  exp_ready;
        logic        exp_rsv;
        logic        exp_ena;
        logic        chk_wr;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [1:0] rv, input logic [4:0] a0, input logic [4:0] a1,
        input logic [31:0] d0, input logic [31:0] d1,
        input logic rsv_v, input logic [4:0] rsv_a, input logic fl,
        input logic [1:0] exp_ready, input logic exp_rsv, input logic exp_ena,
        input logic chk_wr, input logic [4:0] exp_addr, input logic [31:0] exp_data,
        input logic [31:0] exp_busy);
        vec_t v;
        v.rv = rv; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.rsv_v = rsv_v; v.rsv_a = rsv_a; v.fl = fl;
        v.exp_ready = exp_ready; v.exp_rsv = exp_rsv; v.exp_ena = exp_ena;
        v.chk_wr = chk_wr; v.exp_addr = exp_addr; v.exp_data = exp_data;
        v.exp_busy = exp_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        req_valid = v.rv;
        req_addr  = {v.a1, v.a0};
        req_data  = {v.d1, v.d0};
        rsv_valid = v.rsv_v;
        rsv_addr  = v.rsv_a;
        flush     = v.fl;
        #1;
        chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'(v.exp_ready));
        chk($sformatf("v%0d rsv_ready", idx), 32'(rsv_ready), 32'(v.exp_rsv));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d wr_ena", idx), 32'(wr_ena), 32'(v.exp_ena));
        if (v.chk_wr) begin
            chk($sformatf("v%0d wr_addr", idx), 32'(wr_addr), 32'(v.exp_addr));
            chk($sformatf("v%0d wr_data", idx), wr_data, v.exp_data);
        end
        chk($sformatf("v%0d busy", idx), busy, v.exp_busy);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        flush     = 1'b0;

        //       rv    a0     a1     d0            d1            rv rsa   fl  rdy   rr en ck addr   data          busy
        vecs.push_back(mk(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        0, 5'd0, 0, 2'b01, 0, 1, 1, 5'd5, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(2'b00, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        0, 5'd0, 0, 2'b00, 0, 0, 1, 5'd5, 32'hDEADBEEF, 32'h0));
        // x0 write: ptr is 1, lone req0 wins via wrap-around
        vecs.push_back(mk(2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0,        0, 5'd0, 0, 2'b01, 0, 0, 0, 5'd0, 32'h0,        32'h0));
        vecs.push_back(mk(2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1, 5'd7, 0, 2'b00, 1, 0, 0, 5'd0, 32'h0,        32'h80));
        vecs.push_back(mk(2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1, 5'd7, 0, 2'b00, 0, 0, 0, 5'd0, 32'h0,        32'h80));
        vecs.push_back(mk(2'b10, 5'd0, 5'd7, 32'h0,        32'h12345678, 0, 5'd0, 0, 2'b10, 0, 1, 1, 5'd7, 32'h12345678, 32'h0));
        vecs.push_back(mk(2'b00, 5'd0, 5'd7, 32'h0,        32'h12345678, 1, 5'd7, 0, 2'b00, 1, 0, 1, 5'd7, 32'h12345678, 32'h80));
        vecs.push_back(mk(2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1, 5'd9, 0, 2'b00, 1, 0, 0, 5'd0, 32'h0,        32'h280));
        // reserve and write the same register: reservation refused, clear wins
        vecs.push_back(mk(2'b01, 5'd9, 5'd0, 32'hA5A5A5A5, 32'h0,        1, 5'd9, 0, 2'b01, 0, 1, 1, 5'd9, 32'hA5A5A5A5, 32'h80));
        vecs.push_back(mk(2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1, 5'd3, 0, 2'b00, 1, 0, 0, 5'd0, 32'h0,        32'h88));
        vecs.push_back(mk(2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1, 5'd4, 0, 2'b00, 1, 0, 0, 5'd0, 32'h0,        32'h98));
        vecs.push_back(mk(2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1, 5'd31, 0, 2'b00, 1, 0, 0, 5'd0, 32'h0,       32'h80000098));
        // flush with a reservation and a write in the same cycle
        vecs.push_back(mk(2'b10, 5'd0, 5'd20, 32'h0,       32'hCAFEF00D, 1, 5'd12, 1, 2'b10, 0, 1, 1, 5'd20, 32'hCAFEF00D, 32'h0));
        vecs.push_back(mk(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1, 5'd0, 0, 2'b01, 1, 1, 1, 5'd1, 32'h11111111, 32'h0));
        vecs.push_back(mk(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1, 5'd5, 0, 2'b10, 1, 1, 1, 5'd2, 32'h22222222, 32'h20));
        vecs.push_back(mk(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1, 5'd4, 0, 2'b01, 1, 1, 1, 5'd1, 32'h11111111, 32'h30));
        vecs.push_back(mk(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1, 5'd6, 0, 2'b10, 1, 1, 1, 5'd2, 32'h22222222, 32'h70));
        vecs.push_back(mk(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1, 5'd7, 0, 2'b01, 1, 1, 1, 5'd1, 32'h11111111, 32'hF0));

        #1;
        chk("reset wr_ena", 32'(wr_ena), 32'h0);
        chk("reset wr_addr", 32'(wr_addr), 32'h0);
        chk("reset wr_data", wr_data, 32'h0);
        chk("reset busy", busy, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply(i, vecs[i]);

        // Reset mid-cycle while both requesters stream and busy = F0; ptr is 1 here
        rsv_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async rst wr_ena", 32'(wr_ena), 32'h0);
        chk("async rst wr_addr", 32'(wr_addr), 32'h0);
        chk("async rst wr_data", wr_data, 32'h0);
        chk("async rst busy", busy, 32'h0);
        @(posedge clk);
        #1;
        chk("held rst wr_ena", 32'(wr_ena), 32'h0);
        chk("held rst busy", busy, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Round robin after reset: 01,10,01,10 with addresses 1,2,1,2 one cycle later
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d req_ready", k), 32'(req_ready),
                (k % 2 == 0) ? 32'h1 : 32'h2);
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d wr_ena", k), 32'(wr_ena), 32'h1);
            chk($sformatf("rr%0d wr_addr", k), 32'(wr_addr), (k % 2 == 0) ? 32'd1 : 32'd2);
        end

        req_valid = '0;
        #1;
        chk("idle req_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("idle wr_ena", 32'(wr_ena), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (wr_ena/wr_addr/wr_data) between N_REQ writeback requesters, e.g. ALU and load unit, using round-robin arbitration.
- Maintains a 32-entry scoreboard of destinations reserved by issue logic and not yet written back. Issue logic uses the busy vector for RAW/WAW hazard stalls.
- Sits between the execute/memory stages and the register file. The write outputs connect directly to the register file's write channel.

Parameters:
- N_REQ, 2, number of writeback requesters (2..8).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted at 0).
- req_valid  input  N_REQ  requester i has a write pending.
- req_ready  output  N_REQ  requester i's write is accepted this cycle (one-hot or zero).
- req_addr  input  5*N_REQ  destination of requester i, bits [5i+4:5i].
- req_data  input  32*N_REQ  write data of requester i, bits [32i+31:32i].
- rsv_valid  input  1  issue logic requests reservation of rsv_addr.
- rsv_addr  input  5  destination register to reserve.
- rsv_ready  output  1  reservation accepted this cycle.
- flush  input  1  synchronous clear of all reservations (pipeline flush).
- busy  output  32  scoreboard; bit r=1 means register r has a pending write.
- wr_ena  output  1  to register file write enable.
- wr_addr  output  5  to register file write address.
- wr_data  output  32  to register file write data.

Behaviour:
- Reset (rst=0, async): wr_ena=0, wr_addr=0, wr_data=0, busy=0, round-robin pointer=0. Clearing is immediate and not clock-dependent. Reset mid-transfer discards the in-flight write: wr_ena drops at once.
- Arbitration (combinational):
  - Grant goes to the first i with req_valid[i]=1, searching from the pointer upward with wrap N_REQ-1 -> 0.
  - req_ready = one-hot grant; all zero if no req_valid.
  - There is no backpressure: a grant always transfers that cycle.
  - req_ready may depend on req_valid. Requesters hold valid/addr/data stable until ready.
- Pointer: on a clock edge with a grant to i, pointer <= (i+1) mod N_REQ. With no grant, the pointer holds.
- Output stage (registered, 1-cycle latency): on the edge after a grant to i, wr_ena <= 1, wr_addr <= req_addr[i], wr_data <= req_data[i]. With no grant, wr_ena <= 0 and addr/data hold.
- x0 writes: accepted (ready=1) but wr_ena <= 0. The register file never sees an enabled write to address 0.
- Scoreboard set:
  - rsv_ready = rsv_valid & ~busy[rsv_addr] & ~flush.
  - On an edge with rsv_ready=1 and rsv_addr!=0, busy[rsv_addr] <= 1.
  - Reserving x0 is always accepted with no effect; busy[0] is constant 0.
- Scoreboard clear: on an edge with a grant to address r (r!=0), busy[r] <= 0. The clear is tied to acceptance, the same edge that loads wr_*. A write to an unreserved register is legal and the clear is a no-op.
- Simultaneous events:
  - Reserve and accepted write to the same r in one cycle: busy[r] was 1, so rsv_ready=0. The clear wins, and issue retries next cycle.
  - Reserve r and write to a different s: both apply.
  - flush=1: busy <= 0 on that edge, overriding any set. Arbitration and the output stage are unaffected by flush.
- Widths: all arithmetic is unsigned. The pointer is $clog2(N_REQ) bits with explicit wrap (not a power-of-2 overflow).

Test Plan:
1. Reset and basic write: assert rst=0 mid-cycle. Outputs go 0 immediately. Release; req_valid=01, addr0=5, data0=32'hDEADBEEF. Expected: req_ready=01 in the same cycle; next edge wr_ena=1, wr_addr=5, wr_data=DEADBEEF; following cycle wr_ena=0.
2. Round-robin fairness, N_REQ=2: both valid continuously, addr0=1, addr1=2. Expected: grants alternate 01,10,01,10 starting at req0 after reset; wr_addr sequence 1,2,1,2 with 1-cycle lag.
3. x0 suppression: req0 writes addr 0, data FFFFFFFF. Expected: req_ready[0]=1, wr_ena stays 0, busy unchanged.
4. Scoreboard lifecycle: reserve 7 -> rsv_ready=1, busy[7]=1 next cycle. Reserve 7 again -> rsv_ready=0. Requester writes 7 -> busy[7]=0 on the grant edge; reserve 7 then succeeds.
5. Same-cycle collision and flush: busy[9]=1; same cycle reserve 9 plus write 9 -> rsv_ready=0, busy[9]=0 after the edge. Then reserve 3, 4, and 31, and assert flush with rsv_valid=1, rsv_addr=12 -> rsv_ready=0, busy=0 after the edge.
6. Reset during traffic: both requesters streaming, busy=32'h0000_00F0. Pull rst low. Expected: busy=0, wr_ena=0 asynchronously; after release, the first grant goes to req0.
